// File: rtl/if_pkg.sv
// if_pkg -- shared types and constants for the instruction fetch unit.
//   word_t / addr_t : 16-bit instruction word and word address
//   if_state_t      : fetch FSM states
//   if_out_t        : registered IF/ID output bundle
// Optional feature macro used by the top: IF_PERF_CNT_EN.
package if_pkg;

  typedef logic [15:0] word_t;
  typedef logic [15:0] addr_t;

  localparam addr_t IF_RESET_PC  = 16'h0000;
  localparam word_t IF_NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } if_state_t;

  typedef struct packed {
    word_t instr;
    addr_t pc;
    logic  valid;
  } if_out_t;

  // 16-bit increment; wraps FFFF -> 0000 by width.
  function automatic addr_t pc_inc(input addr_t pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// if_hold_buf -- single-entry buffer that parks a fetched instruction while
// the decode side is stalled.
//   clk, reset      : clock, async active-low reset
//   i_load          : capture i_data/i_pc, set full
//   i_unload        : entry consumed, clear full
//   i_clear         : discard entry (flush), clear full
//   i_data, i_pc    : instruction and its address
//   o_data, o_pc    : buffered instruction and address
//   o_full          : entry holds a valid instruction
module if_hold_buf
  import if_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_load,
  input  logic  i_unload,
  input  logic  i_clear,
  input  word_t i_data,
  input  addr_t i_pc,
  output word_t o_data,
  output addr_t o_pc,
  output logic  o_full
);

  word_t r_data;
  addr_t r_pc;
  logic  r_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_pc   <= '0;
      r_full <= 1'b0;
    end else if (i_clear || i_unload) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_pc   <= i_pc;
      r_full <= 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_pc   = r_pc;
  assign o_full = r_full;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit -- single-outstanding-request fetch stage feeding the
// IF/ID register, with stall hold buffer and redirect flush.
//   clk, reset            : clock, async active-low reset
//   imem_req/imem_addr    : memory request, held with stable address until ack
//   imem_ack/imem_rdata   : memory response (variable latency)
//   stall                 : decode holds; registered outputs frozen
//   redirect/redirect_pc  : taken branch; flush and refetch from target
//   instruction_out/pc_out/valid_out : IF/ID outputs
//   fetch_count           : only with IF_PERF_CNT_EN defined; counts every
//                           edge that presents a new valid instruction
module instruction_fetch_unit
  import if_pkg::*;
#(
  parameter addr_t RESET_PC  = IF_RESET_PC,
  parameter word_t NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instruction_out,
  output logic [15:0] pc_out,
  output logic        valid_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  if_state_t r_state, w_state_nxt;
  addr_t     r_fetch_pc, w_fetch_pc_nxt;
  addr_t     r_kill_addr, w_kill_addr_nxt;   // in-flight address being dropped
  if_out_t   r_out, w_out_nxt;

  logic  w_hb_load, w_hb_unload, w_hb_clear, w_hb_full;
  word_t w_hb_data;
  addr_t w_hb_pc;

  if_hold_buf u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_hb_load),
    .i_unload(w_hb_unload),
    .i_clear (w_hb_clear),
    .i_data  (imem_rdata),
    .i_pc    (r_fetch_pc),
    .o_data  (w_hb_data),
    .o_pc    (w_hb_pc),
    .o_full  (w_hb_full)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_kill_addr_nxt = r_kill_addr;
    w_out_nxt       = r_out;
    w_hb_load       = 1'b0;
    w_hb_unload     = 1'b0;
    w_hb_clear      = 1'b0;
    imem_req        = 1'b0;
    imem_addr       = r_fetch_pc;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (redirect) w_fetch_pc_nxt = redirect_pc;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          w_out_nxt.valid = 1'b0;
          w_out_nxt.instr = NOP_INSTR;
          w_fetch_pc_nxt  = redirect_pc;
          // Without an ack the memory still owes us a response for the old
          // address; keep requesting it and throw the data away.
          if (!imem_ack) begin
            w_kill_addr_nxt = r_fetch_pc;
            w_state_nxt     = S_KILL;
          end
        end else if (imem_ack) begin
          w_fetch_pc_nxt = pc_inc(r_fetch_pc);
          if (stall) begin
            w_hb_load   = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_out_nxt = '{instr: imem_rdata, pc: r_fetch_pc, valid: 1'b1};
          end
        end else if (!stall) begin
          w_out_nxt.valid = 1'b0;
          w_out_nxt.instr = NOP_INSTR;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_out_nxt.valid = 1'b0;
          w_out_nxt.instr = NOP_INSTR;
          w_hb_clear      = 1'b1;
          w_fetch_pc_nxt  = redirect_pc;
          w_state_nxt     = S_REQ;
        end else if (!stall && w_hb_full) begin
          w_out_nxt   = '{instr: w_hb_data, pc: w_hb_pc, valid: 1'b1};
          w_hb_unload = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_KILL: begin
        imem_req  = 1'b1;
        imem_addr = r_kill_addr;
        if (redirect) begin
          w_out_nxt.valid = 1'b0;
          w_out_nxt.instr = NOP_INSTR;
          w_fetch_pc_nxt  = redirect_pc;
        end else if (imem_ack) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_kill_addr <= RESET_PC;
      r_out       <= '{instr: NOP_INSTR, pc: 16'h0000, valid: 1'b0};
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_kill_addr <= w_kill_addr_nxt;
      r_out       <= w_out_nxt;
    end
  end

  assign instruction_out = r_out.instr;
  assign pc_out          = r_out.pc;
  assign valid_out       = r_out.valid;

`ifdef IF_PERF_CNT_EN
  logic  w_adv;
  addr_t r_fetch_count;

  // A new valid instruction reaches the outputs either straight from memory
  // or from the hold buffer; redirect always wins over both.
  assign w_adv = !redirect && !stall &&
                 (((r_state == S_REQ) && imem_ack) ||
                  ((r_state == S_HOLD) && w_hb_full));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_fetch_count <= '0;
    else if (w_adv) r_fetch_count <= r_fetch_count + 16'd1;
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] instruction_out;
  logic [15:0] pc_out;
  logic        valid_out;

  int n_chk = 0;
  int n_err = 0;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction_out(instruction_out), .pc_out(pc_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Reference model: what the decode side should see, described as
  // "instructions parked behind a stall" and "responses still owed to a
  // cancelled request", not as a state machine.
  bit          m_started;
  logic [31:0] m_hold[$];   // {pc, instr}
  logic [15:0] m_drop[$];   // addresses whose response must be thrown away
  logic [15:0] m_fpc, m_instr, m_pc;
  logic        m_valid;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'h2F1B) ^ 16'h6C35;
  endfunction

  function automatic logic exp_req();
    return m_started && (m_hold.size() == 0);
  endfunction

  function automatic logic [15:0] exp_addr();
    return (m_drop.size() != 0) ? m_drop[0] : m_fpc;
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_hold.delete();
    m_drop.delete();
    m_fpc = 16'h0000; m_instr = 16'h0000; m_pc = 16'h0000; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic a, input logic st, input logic rd,
                            input logic [15:0] rp, input logic [15:0] d);
    logic fetching;
    fetching = (m_hold.size() == 0) && (m_drop.size() == 0);
    if (!m_started) begin
      m_started = 1;
      if (rd) m_fpc = rp;
    end else if (rd) begin
      m_valid = 1'b0; m_instr = 16'h0000;
      m_hold.delete();
      if (fetching && !a) m_drop.push_back(m_fpc);
      m_fpc = rp;
    end else if (m_drop.size() != 0) begin
      if (a) m_drop.delete();
    end else if (m_hold.size() != 0) begin
      if (!st) begin
        {m_pc, m_instr} = m_hold.pop_front();
        m_valid = 1'b1;
      end
    end else if (a) begin
      if (st) m_hold.push_back({m_fpc, d});
      else begin m_instr = d; m_pc = m_fpc; m_valid = 1'b1; end
      m_fpc = m_fpc + 16'd1;
    end else if (!st) begin
      m_valid = 1'b0; m_instr = 16'h0000;
    end
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, check at next negedge.
  task automatic tick(input logic a, input logic st, input logic rd,
                      input logic [15:0] rp, input logic [15:0] d);
    imem_ack = a; stall = st; redirect = rd; redirect_pc = rp; imem_rdata = d;
    @(posedge clk);
    model_step(a, st, rd, rp, d);
    @(negedge clk);
    chk("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
    chk("instruction_out", {16'd0, instruction_out}, {16'd0, m_instr});
    chk("pc_out", {16'd0, pc_out}, {16'd0, m_pc});
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req()});
    if (exp_req()) chk("imem_addr", {16'd0, imem_addr}, {16'd0, exp_addr()});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_instr"}, {16'd0, instruction_out}, 32'h0000);
    chk({tag, "_pc"}, {16'd0, pc_out}, 32'h0000);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, {16'd0, imem_addr}, 32'h0000);
  endtask

  // Asynchronous reset between edges, with a late ack hanging around.
  task automatic mid_reset();
    #2 reset = 1'b0;
    #1 check_reset_vals("midrst");
    model_reset();
    imem_ack = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic        a, st, rd;
    logic [15:0] rp, d;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    // Back-to-back fetch
    tick(1, 0, 0, 16'h0, 16'h1234);          // idle -> request
    tick(1, 0, 0, 16'h0, 16'h1234);
    chk("b2b_pc0", {16'd0, pc_out}, 32'h0000);
    chk("b2b_v0", {31'd0, valid_out}, 32'd1);
    tick(1, 0, 0, 16'h0, 16'h5678);
    chk("b2b_pc1", {16'd0, pc_out}, 32'h0001);
    chk("b2b_i1", {16'd0, instruction_out}, 32'h5678);

    // Stall while an ack lands
    tick(1, 1, 0, 16'h0, 16'hABCD);
    tick(1, 1, 0, 16'h0, 16'h1111);
    tick(1, 1, 0, 16'h0, 16'h2222);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_frozen", {16'd0, instruction_out}, 32'h5678);
    tick(0, 0, 0, 16'h0, 16'h0);
    chk("unhold_i", {16'd0, instruction_out}, 32'hABCD);

    // Redirect with a late ack
    tick(0, 0, 1, 16'h0040, 16'h0);
    tick(0, 0, 0, 16'h0, 16'h0);
    tick(1, 0, 0, 16'h0, 16'hDEAD);
    chk("redir_valid", {31'd0, valid_out}, 32'd0);
    chk("redir_addr", {16'd0, imem_addr}, 32'h0040);

    // Redirect together with stall
    tick(0, 1, 1, 16'h0080, 16'h0);
    chk("rs_valid", {31'd0, valid_out}, 32'd0);
    chk("rs_instr", {16'd0, instruction_out}, 32'h0000);
    tick(1, 0, 0, 16'h0, 16'hBEEF);
    tick(1, 0, 0, 16'h0, memf(16'h0080));
    chk("rs_pc", {16'd0, pc_out}, 32'h0080);

    // PC wrap
    tick(1, 0, 1, 16'hFFFF, 16'h0BAD);
    tick(1, 0, 0, 16'h0, memf(16'hFFFF));
    chk("wrap_pc", {16'd0, pc_out}, 32'hFFFF);
    chk("wrap_addr", {16'd0, imem_addr}, 32'h0000);

    // Reset with a request outstanding
    tick(0, 0, 0, 16'h0, 16'h0);
    mid_reset();
    tick(1, 0, 0, 16'h0, 16'h7777);
    tick(0, 0, 0, 16'h0, 16'h0);
    chk("late_ack_valid", {31'd0, valid_out}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ((i % 500) == 499 && exp_req()) begin
        mid_reset();
      end else begin
        a  = ($urandom_range(9) < 6);
        st = ($urandom_range(9) < 3);
        rd = ($urandom_range(99) < 7);
        rp = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
        d  = a ? memf(exp_addr()) : 16'($urandom);
        tick(a, st, rd, rp, d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0000: instruction_out value when no instruction is valid.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction memory request, held until imem_ack.
REQ-006 SHALL have port imem_addr  output  16  word address of the request, stable while imem_req=1.
REQ-007 SHALL have port imem_ack  input  1  memory returns imem_rdata this cycle; variable latency, at least 0 cycles.
REQ-008 SHALL have port imem_rdata  input  16  fetched instruction, valid only when imem_ack=1.
REQ-009 SHALL have port stall  input  1  decode side holds; outputs SHALL NOT change while 1.
REQ-010 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc  input  16  redirect target, sampled when redirect=1.
REQ-012 SHALL have port instruction_out  output  16  instruction to the IF/ID pipeline register.
REQ-013 SHALL have port pc_out  output  16  address of instruction_out.
REQ-014 SHALL have port valid_out  output  1  instruction_out/pc_out hold a real instruction.

Function
REQ-015 SHALL use FSM states S_IDLE, S_REQ, S_HOLD and S_KILL; S_IDLE moves to S_REQ on the first clock after reset release.
REQ-016 In S_REQ: imem_req=1, imem_addr=fetch_pc.
REQ-017 In S_REQ with imem_ack, !stall and !redirect: outputs SHALL load {imem_rdata, fetch_pc, 1} next edge, fetch_pc+=1, stay S_REQ; back-to-back throughput is 1 instr/cycle.
REQ-018 In S_REQ with imem_ack, stall=1 and !redirect: SHALL capture rdata/pc in the hold buffer, fetch_pc+=1, go to S_HOLD; outputs unchanged.
REQ-019 In S_HOLD: imem_req=0; when stall falls, the hold buffer SHALL move to the outputs with valid_out=1 and the FSM SHALL go to S_REQ.
REQ-020 With no ack, !stall and !redirect: valid_out SHALL be 0 and instruction_out SHALL be NOP_INSTR next edge (bubble); with stall=1, all outputs SHALL hold.
REQ-021 redirect has highest priority over stall and ack: next edge valid_out=0, instruction_out=NOP_INSTR, hold buffer discarded, fetch_pc=redirect_pc.
REQ-022 redirect in S_REQ without same-cycle ack: SHALL go to S_KILL, keep imem_req=1 with the latched in-flight address until ack, discard that data, then go to S_REQ.
REQ-023 redirect with same-cycle ack: returned data SHALL be discarded and the FSM SHALL go directly to S_REQ.
REQ-024 redirect while in S_KILL: SHALL update the target only and remain in S_KILL.
REQ-025 fetch_pc SHALL be 16-bit unsigned and wrap from 16'hFFFF to 16'h0000.
REQ-026 imem_ack SHALL be ignored in S_IDLE and S_HOLD.

Reset
REQ-027 reset=0 SHALL immediately force: state S_IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, valid_out=0, instruction_out=NOP_INSTR, pc_out=16'h0000, hold buffer empty.
REQ-028 Reset mid-request SHALL abandon the transaction; any late ack SHALL be ignored per REQ-026.

Configuration
REQ-029 Macro IF_PERF_CNT_EN defined: SHALL add output fetch_count [15:0], incremented on each valid_out 0->1 or valid-to-valid advance, wrapping, reset to 0.
REQ-030 Macro IF_PERF_CNT_EN undefined: port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package if_pkg SHALL hold the FSM state enum, the RESET_PC default, NOP_INSTR and the 16-bit word/address typedefs.
REQ-032 The hold buffer SHALL be sub-module if_hold_buf (1 entry: data, pc, full flag, load/unload/clear).

Verification
REQ-033 Reset, release, imem_ack=1 every cycle, rdata=16'h1234,16'h5678 -> pc_out 0000,0001; valid_out 1 from 2nd edge after release.
REQ-034 stall=1 for 3 cycles while ack with 16'hABCD -> outputs frozen, imem_req=0 in S_HOLD; stall falls -> instruction_out=ABCD next edge.
REQ-035 redirect=1, redirect_pc=16'h0040, ack delayed 2 cycles -> stale data dropped, valid_out=0, next imem_addr=0040.
REQ-036 redirect and stall asserted together -> valid_out=0, instruction_out=16'h0000, fetch resumes at redirect_pc.
REQ-037 fetch_pc=16'hFFFF, ack -> pc_out=FFFF, next imem_addr=0000.
REQ-038 reset asserted during outstanding request -> all outputs at reset values immediately; later ack produces no valid_out.
